add_round_sequencer: RTL and testbench

//  Sequences the shared 256-lane polynomial adder for Kyber encryption. Five rounds:
//  u[i]=x[i]+e_1[i] for i=0..2, v=y+e_2, v=v+msg_poly.

---
 rtl/add_round_sequencer_if.sv | 41 ++++
 rtl/add_round_sequencer.sv | 138 +++++++++++++
 tb/tb_add_round_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/add_round_sequencer_if.sv
// add_round_sequencer_if
//  Bundles the sequencer's control handshake, adder operand-select/issue,
//  lane-sum input and the reduced u/v result buses.
//  master : the sequencer side (drives busy/done/add_sel/add_en/u0..u2/v/range_err,
//           receives start and add_sum)
//  slave  : the controller/adder side (drives start and add_sum)
//  Signals:
//   start      begin a five-round sequence
//   busy       sequence in progress
//   done       one-cycle completion pulse
//   add_sel    adder operand-select (0..2 u rounds, 3 y/e_2, 4 v/msg_poly)
//   add_en     one-cycle operand-issue strobe
//   add_sum    N lane sums, 13 bits each
//   u0,u1,u2   reduced u polynomials, 16 bits per lane
//   v          reduced v polynomial, 16 bits per lane
//   range_err  sticky out-of-range lane sum flag
interface add_round_sequencer_if #(
  parameter int N = 256
);
  logic            start;
  logic            busy;
  logic            done;
  logic [2:0]      add_sel;
  logic            add_en;
  logic [N*13-1:0] add_sum;
  logic [N*16-1:0] u0;
  logic [N*16-1:0] u1;
  logic [N*16-1:0] u2;
  logic [N*16-1:0] v;
  logic            range_err;

  modport master (
    input  start, add_sum,
    output busy, done, add_sel, add_en, u0, u1, u2, v, range_err
  );

  modport slave (
    output start, add_sum,
    input  busy, done, add_sel, add_en, u0, u1, u2, v, range_err
  );
endinterface

// File: rtl/add_round_sequencer.sv
// add_round_sequencer
//  Runs the five addition rounds of Kyber encryption on the shared 256-lane
//  adder: u[0..2] = x[i] + e_1[i], v = y + e_2, then v = v + msg_poly.
//  Each round issues operands for one cycle, waits ADD_LAT cycles, then
//  captures the lane sums reduced once by Q into the matching result register.
//  Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  add_round_sequencer_if master modport (handshake, adder, results)
module add_round_sequencer #(
  parameter int N       = 256,
  parameter int Q       = 3329,
  parameter int ADD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  add_round_sequencer_if.master   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] LAST_ROUND = 3'd4;
  localparam int         CNT_W      = $clog2(ADD_LAT + 1);

  logic [1:0]      state_q, state_d;
  logic [2:0]      round_q, round_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic            rangeErr_q, rangeErr_d;
  logic [N*16-1:0] u0_q, u0_d;
  logic [N*16-1:0] u1_q, u1_d;
  logic [N*16-1:0] u2_q, u2_d;
  logic [N*16-1:0] v_q, v_d;

  logic [N*16-1:0] redSum;
  logic [N-1:0]    laneOver;
  logic            captureEn;

  // Single conditional subtraction per lane. A sum at or above 2Q is only
  // partially reduced; it is flagged rather than reduced a second time.
  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [12:0] laneSum;
    assign laneSum             = bus.add_sum[13*j +: 13];
    assign laneOver[j]         = (laneSum >= 13'(2 * Q));
    assign redSum[16*j +: 16]  = {3'b000, (laneSum >= 13'(Q)) ? (laneSum - 13'(Q)) : laneSum};
  end

  // The capture edge closes the last WAIT cycle; add_sum is looked at
  // nowhere else, so undefined adder output between captures cannot leak.
  assign captureEn = (state_q == ST_WAIT) && (count_q == CNT_W'(1));

  // Next-state logic. The round-4 operand is v itself, so v is written only
  // at a capture edge and stays stable while the adder is working on it.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    count_d    = count_q;
    rangeErr_d = rangeErr_q;
    u0_d       = u0_q;
    u1_d       = u1_q;
    u2_d       = u2_q;
    v_d        = v_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_ISSUE;
          round_d    = 3'd0;
          rangeErr_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        count_d = CNT_W'(ADD_LAT);
      end
      ST_WAIT: begin
        count_d = count_q - CNT_W'(1);
        if (captureEn) begin
          rangeErr_d = rangeErr_q | (|laneOver);
          case (round_q)
            3'd0:    u0_d = redSum;
            3'd1:    u1_d = redSum;
            3'd2:    u2_d = redSum;
            default: v_d  = redSum;
          endcase
          if (round_q == LAST_ROUND) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_q + 3'd1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      round_q    <= 3'd0;
      count_q    <= '0;
      rangeErr_q <= 1'b0;
      u0_q       <= '0;
      u1_q       <= '0;
      u2_q       <= '0;
      v_q        <= '0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      count_q    <= count_d;
      rangeErr_q <= rangeErr_d;
      u0_q       <= u0_d;
      u1_q       <= u1_d;
      u2_q       <= u2_d;
      v_q        <= v_d;
    end
  end

  // add_sel is the round register itself, so it only moves when ISSUE is entered.
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.add_en    = (state_q == ST_ISSUE);
  assign bus.add_sel   = round_q;
  assign bus.range_err = rangeErr_q;
  assign bus.u0        = u0_q;
  assign bus.u1        = u1_q;
  assign bus.u2        = u2_q;
  assign bus.v         = v_q;

endmodule

// File: tb/tb_add_round_sequencer.sv
// tb_add_round_sequencer
//  Drives two sequencers (ADD_LAT=1 and ADD_LAT=3) and compares every output
//  with a lane-array model built from the round/reduction/timing rules.
//  Outputs are sampled on the falling clock edge.
module tb_add_round_sequencer;

  localparam int N = 256;
  localparam int Q = 3329;

  logic clk;
  logic rst;

  int checks;
  int errors;

  // Model registers: 0..2 = u0..u2, 3 = v for the ADD_LAT=1 unit, 4 = results of the ADD_LAT=3 unit.
  int expReg[5][N];
  bit expErr;
  int sum[N];

  add_round_sequencer_if #(.N(N)) busA ();
  add_round_sequencer_if #(.N(N)) busB ();

  add_round_sequencer #(.N(N), .Q(Q), .ADD_LAT(1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  add_round_sequencer #(.N(N), .Q(Q), .ADD_LAT(3)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutputPoly(input string tag, input logic [N*16-1:0] obs, input int idx);
    logic [N*16-1:0] expVec;
    int bad;
    for (int j = 0; j < N; j++) expVec[16*j +: 16] = 16'(expReg[idx][j]);
    checks++;
    assert (obs === expVec) else begin
      errors++;
      bad = 0;
      for (int j = N - 1; j >= 0; j--) if (obs[16*j +: 16] !== expVec[16*j +: 16]) bad = j;
      $error("[TB] FAIL %s: lane %0d observed=%0d expected=%0d", tag, bad,
             obs[16*bad +: 16], expVec[16*bad +: 16]);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 5; i++) for (int j = 0; j < N; j++) expReg[i][j] = 0;
    expErr = 1'b0;
  endtask

  // Kyber lane reduction as the block defines it: one subtraction of Q at most.
  function automatic int reduceLane(input int s);
    return (s >= Q) ? s - Q : s;
  endfunction

  task automatic checkAllPolys(input string tag);
    checkOutputPoly({tag, "_u0"}, busA.u0, 0);
    checkOutputPoly({tag, "_u1"}, busA.u1, 1);
    checkOutputPoly({tag, "_u2"}, busA.u2, 2);
    checkOutputPoly({tag, "_v"},  busA.v,  3);
  endtask

  // One sequence on the ADD_LAT=1 unit. mode: 0 random, 1 constant 100 with
  // reduction corner lanes, 2 range error in round 1 lane 5, 3 directed v
  // feedback, 4 random v feedback. abortAt >= 0 resets mid-WAIT of that round.
  task automatic applyStimulus(input int mode, input int abortAt, input bit noisy);
    int cyc;
    int msg;
    int tgt;
    checkOutput("idle_before_start", busA.busy, 1'b0);
    busA.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    busA.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    checkOutput("busy_after_accept", busA.busy, 1'b1);
    checkOutput("range_err_cleared", busA.range_err, 1'b0);
    expErr = 1'b0;
    for (int r = 0; r < 5; r++) begin
      checkOutput($sformatf("add_en_issue_r%0d", r), busA.add_en, 1'b1);
      checkOutput($sformatf("add_sel_issue_r%0d", r), busA.add_sel, r);
      busA.add_sum = 'x;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      busA.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      checkOutput($sformatf("add_en_wait_r%0d", r), busA.add_en, 1'b0);
      checkOutput($sformatf("add_sel_wait_r%0d", r), busA.add_sel, r);
      checkOutput($sformatf("done_low_c%0d", cyc), busA.done, 1'b0);
      if (r == abortAt) begin
        rst = 1'b1;
        busA.start = 1'b0;
        #1;
        clearModel();
        checkOutput("abort_busy", busA.busy, 1'b0);
        checkOutput("abort_add_en", busA.add_en, 1'b0);
        checkOutput("abort_done", busA.done, 1'b0);
        checkOutput("abort_add_sel", busA.add_sel, 0);
        checkOutput("abort_range_err", busA.range_err, 1'b0);
        checkAllPolys("abort");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (r == 4) checkOutputPoly("v_stable_r4", busA.v, 3);
      msg = $urandom_range(0, Q - 1);
      for (int j = 0; j < N; j++) begin
        case (mode)
          1: sum[j] = (r == 0 && j == 0) ? 3329 : (r == 0 && j == 1) ? 3328 :
                      (r == 0 && j == 2) ? 6657 : 100;
          2: sum[j] = (r == 1 && j == 5) ? 6658 : int'($urandom_range(0, 2 * Q - 1));
          3: sum[j] = (r == 3) ? 3000 : (r == 4) ? expReg[3][j] + 500 :
                      int'($urandom_range(0, 2 * Q - 1));
          4: sum[j] = (r == 4) ? expReg[3][j] + int'($urandom_range(0, Q - 1)) :
                      int'($urandom_range(0, 2 * Q - 1));
          default: sum[j] = $urandom_range(0, 2 * Q - 1);
        endcase
        busA.add_sum[13*j +: 13] = 13'(sum[j]);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      busA.add_sum = 'x;
      tgt = (r < 3) ? r : 3;
      for (int j = 0; j < N; j++) begin
        if (sum[j] >= 2 * Q) expErr = 1'b1;
        expReg[tgt][j] = reduceLane(sum[j]);
      end
      checkOutputPoly($sformatf("capture_m%0d_r%0d", mode, r),
                      (tgt == 0) ? busA.u0 : (tgt == 1) ? busA.u1 :
                      (tgt == 2) ? busA.u2 : busA.v, tgt);
      checkOutput($sformatf("range_err_m%0d_r%0d", mode, r), busA.range_err, expErr);
    end
    checkOutput($sformatf("done_c%0d", cyc), busA.done, 1'b1);
    checkOutput("busy_in_done", busA.busy, 1'b1);
    checkOutput("add_en_in_done", busA.add_en, 1'b0);
    busA.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busA.start = 1'b0;
    checkOutput("busy_after_done", busA.busy, 1'b0);
    checkOutput("done_after_done", busA.done, 1'b0);
    checkOutput("range_err_after_done", busA.range_err, expErr);
    checkAllPolys($sformatf("final_m%0d", mode));
  endtask

  // Main directed sequence.
  initial begin
    int p;
    checks = 0;
    errors = 0;
    clearModel();
    rst = 1'b1;
    busA.start = 1'b0;
    busA.add_sum = '0;
    busB.start = 1'b0;
    busB.add_sum = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busA.busy, 1'b0);
    checkOutput("reset_done", busA.done, 1'b0);
    checkOutput("reset_add_en", busA.add_en, 1'b0);
    checkOutput("reset_add_sel", busA.add_sel, 0);
    checkOutput("reset_range_err", busA.range_err, 1'b0);
    checkAllPolys("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] nominal sums of 100 with reduction corner lanes");
    applyStimulus(1, -1, 1'b0);
    $display("[TB] range error in round 1 lane 5");
    applyStimulus(2, -1, 1'b0);
    $display("[TB] random sums, range flag must clear on start");
    applyStimulus(0, -1, 1'b1);
    $display("[TB] v feedback 3000 + 500");
    applyStimulus(3, -1, 1'b0);
    $display("[TB] random v feedback with start noise while busy");
    applyStimulus(4, -1, 1'b1);
    $display("[TB] reset in round 2 wait");
    applyStimulus(0, 2, 1'b0);
    applyStimulus(0, -1, 1'b0);

    $display("[TB] ADD_LAT=3 with start held high");
    for (int j = 0; j < N; j++) begin
      sum[j] = $urandom_range(0, 2 * Q - 1);
      busB.add_sum[13*j +: 13] = 13'(sum[j]);
      expReg[4][j] = reduceLane(sum[j]);
    end
    busB.start = 1'b1;
    p = 0;
    for (int i = 0; i < 66; i++) begin
      @(posedge clk);
      @(negedge clk);
      p = (p == 21) ? 0 : p + 1;
      checkOutput($sformatf("b_busy_p%0d", p), busB.busy, (p != 0));
      checkOutput($sformatf("b_done_p%0d", p), busB.done, (p == 21));
      checkOutput($sformatf("b_add_en_p%0d", p), busB.add_en,
                  (p >= 1 && p <= 17 && ((p - 1) % 4) == 0));
      if (p >= 1 && p <= 20) checkOutput($sformatf("b_add_sel_p%0d", p), busB.add_sel, (p - 1) / 4);
    end
    busB.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b_idle_after_release", busB.busy, 1'b0);
    checkOutput("b_range_err", busB.range_err, 1'b0);
    checkOutputPoly("b_u0", busB.u0, 4);
    checkOutputPoly("b_u1", busB.u1, 4);
    checkOutputPoly("b_u2", busB.u2, 4);
    checkOutputPoly("b_v",  busB.v,  4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
